decode_stage: RTL and testbench

//  RV32I decode pipeline stage: accepts fetched instr+PC, emits one registered

---
 rtl/decode_stage_pkg.sv | 87 ++++++++
 rtl/decode_stage_instr_decoder.sv | 150 +++++++++++++++
 rtl/decode_stage.sv | 85 ++++++++
 tb/tb_decode_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode types: ALU/branch/memory/writeback encodings, RV32I opcodes and
// the registered execute bundle that the decode stage hands to execute.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD    = 4'd0,
    ALU_OP_SUB    = 4'd1,
    ALU_OP_AND    = 4'd2,
    ALU_OP_OR     = 4'd3,
    ALU_OP_XOR    = 4'd4,
    ALU_OP_SLL    = 4'd5,
    ALU_OP_SRL    = 4'd6,
    ALU_OP_SRA    = 4'd7,
    ALU_OP_SLT    = 4'd8,
    ALU_OP_SLTU   = 4'd9,
    ALU_OP_COPY_B = 4'd10
  } alu_op_t;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_EQ   = 4'd1,
    BR_NE   = 4'd2,
    BR_LT   = 4'd3,
    BR_GE   = 4'd4,
    BR_LTU  = 4'd5,
    BR_GEU  = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_type_t;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_t     alu_op;
    logic        a_sel;
    logic        b_sel;
    br_type_t    br;
    mem_op_t     mem;
    wb_sel_t     wb_sel;
    logic        wb_en;
    logic        illegal;
  } decode_bundle_t;

  // Idle bundle: everything zero, which also encodes ADD/NONE/ALU.
  function automatic decode_bundle_t bundle_idle();
    decode_bundle_t b;
    b        = '0;
    b.alu_op = ALU_OP_ADD;
    b.br     = BR_NONE;
    b.mem    = MEM_NONE;
    b.wb_sel = WB_ALU;
    return b;
  endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Purely combinational RV32I decoder: raw instruction -> execute bundle.
// Fields the instruction format does not use are left at zero.
module instr_decoder
  import decode_stage_pkg::*;
(
  input  logic [31:0]    instr,
  output decode_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        rd_used;
  logic        ill;
  decode_bundle_t d;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    d       = bundle_idle();
    rd_used = 1'b0;
    ill     = 1'b0;

    case (opcode)
      OPC_OP_IMM: begin
        d.rs1 = rs1; d.rd = rd; rd_used = 1'b1;
        d.b_sel = 1'b1; d.imm = imm_i;
        case (funct3)
          3'b000: d.alu_op = ALU_OP_ADD;
          3'b010: d.alu_op = ALU_OP_SLT;
          3'b011: d.alu_op = ALU_OP_SLTU;
          3'b100: d.alu_op = ALU_OP_XOR;
          3'b110: d.alu_op = ALU_OP_OR;
          3'b111: d.alu_op = ALU_OP_AND;
          3'b001: begin
            d.alu_op = ALU_OP_SLL; d.imm = imm_sh;
            ill = (funct7 != 7'h00);
          end
          default: begin
            d.imm = imm_sh;
            if (funct7 == 7'h00)      d.alu_op = ALU_OP_SRL;
            else if (funct7 == 7'h20) d.alu_op = ALU_OP_SRA;
            else                      ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; rd_used = 1'b1;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'b000:  d.alu_op = ALU_OP_ADD;
            3'b001:  d.alu_op = ALU_OP_SLL;
            3'b010:  d.alu_op = ALU_OP_SLT;
            3'b011:  d.alu_op = ALU_OP_SLTU;
            3'b100:  d.alu_op = ALU_OP_XOR;
            3'b101:  d.alu_op = ALU_OP_SRL;
            3'b110:  d.alu_op = ALU_OP_OR;
            default: d.alu_op = ALU_OP_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'b000) d.alu_op = ALU_OP_SUB;
        else if (funct7 == 7'h20 && funct3 == 3'b101)     d.alu_op = ALU_OP_SRA;
        else ill = 1'b1;
      end
      OPC_LUI: begin
        d.rd = rd; rd_used = 1'b1;
        d.alu_op = ALU_OP_COPY_B; d.b_sel = 1'b1; d.imm = imm_u;
      end
      OPC_AUIPC: begin
        d.rd = rd; rd_used = 1'b1;
        d.a_sel = 1'b1; d.b_sel = 1'b1; d.imm = imm_u;
      end
      OPC_JAL: begin
        d.rd = rd; rd_used = 1'b1;
        d.a_sel = 1'b1; d.b_sel = 1'b1; d.imm = imm_j;
        d.wb_sel = WB_PC4; d.br = BR_JAL;
      end
      OPC_JALR: begin
        d.rs1 = rs1; d.rd = rd; rd_used = 1'b1;
        d.b_sel = 1'b1; d.imm = imm_i;
        d.wb_sel = WB_PC4; d.br = BR_JALR;
        ill = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        // Execute resolves the condition from the SUB result flags.
        d.rs1 = rs1; d.rs2 = rs2; d.imm = imm_b; d.alu_op = ALU_OP_SUB;
        case (funct3)
          3'b000:  d.br = BR_EQ;
          3'b001:  d.br = BR_NE;
          3'b100:  d.br = BR_LT;
          3'b101:  d.br = BR_GE;
          3'b110:  d.br = BR_LTU;
          3'b111:  d.br = BR_GEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.rs1 = rs1; d.rd = rd; rd_used = 1'b1;
        d.b_sel = 1'b1; d.imm = imm_i; d.wb_sel = WB_MEM;
        case (funct3)
          3'b000:  d.mem = MEM_LB;
          3'b001:  d.mem = MEM_LH;
          3'b010:  d.mem = MEM_LW;
          3'b100:  d.mem = MEM_LBU;
          3'b101:  d.mem = MEM_LHU;
          default: ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d.rs1 = rs1; d.rs2 = rs2;
        d.b_sel = 1'b1; d.imm = imm_s;
        case (funct3)
          3'b000:  d.mem = MEM_SB;
          3'b001:  d.mem = MEM_SH;
          3'b010:  d.mem = MEM_SW;
          default: ill = 1'b1;
        endcase
      end
      OPC_MISC_MEM: ill = (funct3 != 3'b000);
      OPC_SYSTEM:   ill = 1'b1;
      default:      ill = 1'b1;
    endcase

    if (instr[1:0] != 2'b11) ill = 1'b1;

    d.illegal = ill;
    d.wb_en   = rd_used && (rd != 5'd0) && !ill;
    if (ill) begin
      d.mem = MEM_NONE;
      d.br  = BR_NONE;
    end
  end

  assign bundle = d;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: valid/ready handshake around a single registered
// execute bundle, with flush from the branch unit.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output alu_op_t         out_alu_op,
  output logic            out_a_sel,
  output logic            out_b_sel,
  output br_type_t        out_br,
  output mem_op_t         out_mem,
  output wb_sel_t         out_wb_sel,
  output logic            out_wb_en,
  output logic            out_illegal
);

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_stage supports XLEN=32 only");
  end

  decode_bundle_t  dec_bundle;
  decode_bundle_t  bundle_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic            accept;

  instr_decoder u_decoder (
    .instr  (in_instr),
    .bundle (dec_bundle)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Payload only changes on accept, so a stalled bundle stays bit-stable.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= RESET_PC;
      // NOTE: the payload is reset as well (not just valid) so outputs are defined zeros after reset.
      bundle_q <= bundle_idle();
    end else if (flush) begin
      valid_q  <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      pc_q     <= in_pc;
      bundle_q <= dec_bundle;
    end else if (out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_rs1     = bundle_q.rs1;
  assign out_rs2     = bundle_q.rs2;
  assign out_rd      = bundle_q.rd;
  assign out_imm     = bundle_q.imm;
  assign out_alu_op  = bundle_q.alu_op;
  assign out_a_sel   = bundle_q.a_sel;
  assign out_b_sel   = bundle_q.b_sel;
  assign out_br      = bundle_q.br;
  assign out_mem     = bundle_q.mem;
  assign out_wb_sel  = bundle_q.wb_sel;
  assign out_wb_en   = bundle_q.wb_en;
  assign out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles are queued when an
// instruction is driven and compared when the stage presents it.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  alu_op_t     out_alu_op;
  logic        out_a_sel, out_b_sel;
  br_type_t    out_br;
  mem_op_t     out_mem;
  wb_sel_t     out_wb_sel;
  logic        out_wb_en;
  logic        out_illegal;

  typedef struct {
    logic [31:0]    pc;
    decode_bundle_t b;
    bit             ill_only;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  decode_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
    .out_br(out_br), .out_mem(out_mem), .out_wb_sel(out_wb_sel),
    .out_wb_en(out_wb_en), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic decode_bundle_t base();
    decode_bundle_t b;
    b        = '0;
    b.alu_op = ALU_OP_ADD;
    b.br     = BR_NONE;
    b.mem    = MEM_NONE;
    b.wb_sel = WB_ALU;
    return b;
  endfunction

  // Compare the presented bundle against the scoreboard head; pop when consumed.
  task automatic check_out(input bit pop);
    exp_t e;
    check("out_valid", 32'(out_valid), 32'd1);
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb[0];
    check("pc", out_pc, e.pc);
    check("illegal", 32'(out_illegal), 32'(e.b.illegal));
    check("wb_en", 32'(out_wb_en), 32'(e.b.wb_en));
    check("mem", 32'(out_mem), 32'(e.b.mem));
    check("br", 32'(out_br), 32'(e.b.br));
    if (!e.ill_only) begin
      check("rs1", 32'(out_rs1), 32'(e.b.rs1));
      check("rs2", 32'(out_rs2), 32'(e.b.rs2));
      check("rd", 32'(out_rd), 32'(e.b.rd));
      check("imm", out_imm, e.b.imm);
      check("alu_op", 32'(out_alu_op), 32'(e.b.alu_op));
      check("a_sel", 32'(out_a_sel), 32'(e.b.a_sel));
      check("b_sel", 32'(out_b_sel), 32'(e.b.b_sel));
      check("wb_sel", 32'(out_wb_sel), 32'(e.b.wb_sel));
    end
    if (pop) void'(sb.pop_front());
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input decode_bundle_t b, input bit ill_only);
    exp_t e;
    e.pc = pc; e.b = b; e.ill_only = ill_only;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input decode_bundle_t b, input bit ill_only);
    drive(instr, pc, b, ill_only);
    step();
    in_valid = 1'b0;
    check_out(1'b1);
  endtask

  decode_bundle_t b;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    step(); step();

    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_alu_op", 32'(out_alu_op), 32'(ALU_OP_ADD));
    check("rst_imm", out_imm, 32'h0);
    check("rst_rd", 32'(out_rd), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // addi x1,x0,5
    b = base(); b.rd = 5'd1; b.imm = 32'd5; b.b_sel = 1'b1; b.wb_en = 1'b1;
    send(32'h00500093, 32'h100, b, 1'b0);
    // sub x3,x1,x2
    b = base(); b.rs1 = 5'd1; b.rs2 = 5'd2; b.rd = 5'd3; b.alu_op = ALU_OP_SUB; b.wb_en = 1'b1;
    send(32'h402081B3, 32'h104, b, 1'b0);
    // srai x5,x6,3
    b = base(); b.rs1 = 5'd6; b.rd = 5'd5; b.imm = 32'd3; b.alu_op = ALU_OP_SRA;
    b.b_sel = 1'b1; b.wb_en = 1'b1;
    send(32'h40335293, 32'h108, b, 1'b0);
    // lui x7,0x12345
    b = base(); b.rd = 5'd7; b.imm = 32'h12345000; b.alu_op = ALU_OP_COPY_B;
    b.b_sel = 1'b1; b.wb_en = 1'b1;
    send(32'h123453B7, 32'h10C, b, 1'b0);
    // addi x0,x0,0: rd==0 suppresses writeback
    b = base(); b.b_sel = 1'b1;
    send(32'h00000013, 32'h110, b, 1'b0);
    // lw x8,-4(x2)
    b = base(); b.rs1 = 5'd2; b.rd = 5'd8; b.imm = 32'hFFFFFFFC; b.b_sel = 1'b1;
    b.mem = MEM_LW; b.wb_sel = WB_MEM; b.wb_en = 1'b1;
    send(32'hFFC12403, 32'h114, b, 1'b0);
    // beq x1,x2,+8
    b = base(); b.rs1 = 5'd1; b.rs2 = 5'd2; b.imm = 32'd8; b.alu_op = ALU_OP_SUB; b.br = BR_EQ;
    send(32'h00208463, 32'h118, b, 1'b0);
    // sw x5,12(x1)
    b = base(); b.rs1 = 5'd1; b.rs2 = 5'd5; b.imm = 32'd12; b.b_sel = 1'b1; b.mem = MEM_SW;
    send(32'h0050A623, 32'h11C, b, 1'b0);
    // jal x1,+16
    b = base(); b.rd = 5'd1; b.imm = 32'd16; b.a_sel = 1'b1; b.b_sel = 1'b1;
    b.br = BR_JAL; b.wb_sel = WB_PC4; b.wb_en = 1'b1;
    send(32'h010000EF, 32'h120, b, 1'b0);
    // all-zero word and ecall are illegal
    b = base(); b.illegal = 1'b1;
    send(32'h00000000, 32'h124, b, 1'b1);
    send(32'h00000073, 32'h128, b, 1'b1);

    step();
    check("idle_valid", 32'(out_valid), 32'd0);

    // Back-pressure: bundle A held while B waits for three cycles.
    out_ready = 1'b0;
    b = base(); b.rd = 5'd1; b.imm = 32'd5; b.b_sel = 1'b1; b.wb_en = 1'b1;
    drive(32'h00500093, 32'h200, b, 1'b0);
    step();
    b = base(); b.rs1 = 5'd1; b.rs2 = 5'd2; b.rd = 5'd3; b.alu_op = ALU_OP_SUB; b.wb_en = 1'b1;
    drive(32'h402081B3, 32'h204, b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check_out(1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check_out(1'b1);
    step();
    in_valid = 1'b0;
    check_out(1'b1);
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Flush with a held bundle and a concurrent input: both are discarded.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h300;
    step();
    check("pre_flush_valid", 32'(out_valid), 32'd1);
    in_instr = 32'h402081B3; in_pc = 32'h304; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_pc_kept", out_pc, 32'h300);
    step();
    check("flush_dropped", 32'(out_valid), 32'd0);

    // Reset while stalled drops the bundle.
    in_valid = 1'b1; in_instr = 32'h123453B7; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    check("rst_stall_valid", 32'(out_valid), 32'd0);
    check("rst_stall_pc", out_pc, 32'h0);
    check("rst_stall_imm", out_imm, 32'h0);
    rst = 1'b0; out_ready = 1'b1;

    // Recovery after reset.
    b = base(); b.rd = 5'd1; b.imm = 32'd5; b.b_sel = 1'b1; b.wb_en = 1'b1;
    send(32'h00500093, 32'h500, b, 1'b0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
